audio_level_meter: RTL and testbench



---
 rtl/audio_level_meter.sv | 197 +++++++++++++++++++
 tb/tb_audio_level_meter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_level_meter.sv
// Stereo level meter: rectify/max, fast-attack slow-decay envelope, clip hold and 8-LED bar graph.
// Build option METER_PEAK_DOT_EN adds the held peak register and the peak dot on the bar.
module audio_level_meter #(
  parameter int unsigned DECAY_SHIFT  = 4,
  parameter int unsigned DECAY_DIV    = 64,
  parameter int unsigned HOLD_SAMPLES = 24000,
  parameter int unsigned CLIP_THRESH  = 131000
) (
  input  logic        clockext100MHz,
  input  logic        reset,
  input  logic        sample_ready,
  input  logic [17:0] left_in,
  input  logic [17:0] right_in,
  output logic [7:0]  ld,
  output logic [17:0] env_level,
  output logic [17:0] peak_level,
  output logic        clip,
  output logic        level_ready
);

  localparam int unsigned DecW  = (DECAY_DIV > 2) ? $clog2(DECAY_DIV) : 1;
  localparam int unsigned HoldW = (HOLD_SAMPLES > 2) ? $clog2(HOLD_SAMPLES) : 1;
  localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD_SAMPLES - 1);

  // ---------------------------------------------------------------------------
  // S1: rectify and take the louder channel
  // ---------------------------------------------------------------------------
  logic [17:0] abs_l, abs_r, m_s1;
  logic        clip_hit_s1;

  always_comb begin
    abs_l       = left_in[17] ? (~left_in + 18'd1) : left_in;
    abs_r       = right_in[17] ? (~right_in + 18'd1) : right_in;
    m_s1        = (abs_l > abs_r) ? abs_l : abs_r;
    clip_hit_s1 = ({14'd0, m_s1} >= CLIP_THRESH);
  end

  logic        vld1_q;
  logic [17:0] m_q;
  logic        clip_hit_q;

  always_ff @(posedge clockext100MHz) begin
    if (reset) begin
      vld1_q     <= 1'b0;
      m_q        <= '0;
      clip_hit_q <= 1'b0;
    end else begin
      vld1_q <= sample_ready;
      if (sample_ready) begin
        m_q        <= m_s1;
        clip_hit_q <= clip_hit_s1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: envelope, clip hold and (optionally) peak hold
  // ---------------------------------------------------------------------------
  logic             vld2_q;
  logic [DecW-1:0]  dec_cnt_q, dec_cnt_d;
  logic [17:0]      env_q, env_d;
  logic [17:0]      env_step;
  logic             tick;
  logic [HoldW-1:0] clip_cnt_q, clip_cnt_d;
  logic             clip_q, clip_d;

  always_comb begin
    dec_cnt_d  = dec_cnt_q;
    env_d      = env_q;
    clip_cnt_d = clip_cnt_q;
    clip_d     = clip_q;
    tick       = 1'b0;
    env_step   = env_q >> DECAY_SHIFT;
    // Small envelopes still release by one LSB so they reach zero exactly.
    if (env_step == '0) begin
      env_step = 18'd1;
    end
    if (vld1_q) begin
      dec_cnt_d = dec_cnt_q + DecW'(1);
      tick      = (dec_cnt_d == '0);
      if (m_q > env_q) begin
        env_d = m_q;
      end else if (tick && (env_q != '0)) begin
        env_d = env_q - env_step;
      end
      if (clip_hit_q) begin
        clip_cnt_d = HoldInit;
        clip_d     = 1'b1;
      end else if (clip_cnt_q == '0) begin
        clip_d = 1'b0;
      end else begin
        clip_cnt_d = clip_cnt_q - HoldW'(1);
      end
    end
  end

  always_ff @(posedge clockext100MHz) begin
    if (reset) begin
      vld2_q     <= 1'b0;
      dec_cnt_q  <= '0;
      env_q      <= '0;
      clip_cnt_q <= '0;
      clip_q     <= 1'b0;
    end else begin
      vld2_q     <= vld1_q;
      dec_cnt_q  <= dec_cnt_d;
      env_q      <= env_d;
      clip_cnt_q <= clip_cnt_d;
      clip_q     <= clip_d;
    end
  end

  logic [17:0] peak_s2;

`ifdef METER_PEAK_DOT_EN
  logic [17:0]      peak_q, peak_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    peak_d     = peak_q;
    hold_cnt_d = hold_cnt_q;
    if (vld1_q) begin
      if (m_q >= peak_q) begin
        peak_d     = m_q;
        hold_cnt_d = HoldInit;
      end else if (hold_cnt_q != '0) begin
        hold_cnt_d = hold_cnt_q - HoldW'(1);
      end else begin
        peak_d = env_d;
      end
    end
  end

  always_ff @(posedge clockext100MHz) begin
    if (reset) begin
      peak_q     <= '0;
      hold_cnt_q <= '0;
    end else begin
      peak_q     <= peak_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign peak_s2 = peak_q;
`else
  assign peak_s2 = env_q;
`endif

  // ---------------------------------------------------------------------------
  // S3: bar graph (6 dB per LED starting at 512) and output registers
  // ---------------------------------------------------------------------------
  logic [7:0] bar, dot, ld_d;

  always_comb begin
    bar = '0;
    dot = '0;
    for (int k = 0; k < 8; k++) begin
      bar[k] = (env_q >= (18'd1 << (9 + k)));
`ifdef METER_PEAK_DOT_EN
      // Later iterations overwrite, leaving only the highest crossed threshold.
      if (peak_s2 >= (18'd1 << (9 + k))) begin
        dot = 8'd1 << k;
      end
`endif
    end
    ld_d = bar | dot;
  end

  logic [7:0]  ld_q;
  logic [17:0] env_level_q, peak_level_q;
  logic        clip_out_q, level_ready_q;

  always_ff @(posedge clockext100MHz) begin
    if (reset) begin
      ld_q          <= '0;
      env_level_q   <= '0;
      peak_level_q  <= '0;
      clip_out_q    <= 1'b0;
      level_ready_q <= 1'b0;
    end else begin
      level_ready_q <= vld2_q;
      if (vld2_q) begin
        ld_q         <= ld_d;
        env_level_q  <= env_q;
        peak_level_q <= peak_s2;
        clip_out_q   <= clip_q;
      end
    end
  end

  assign ld          = ld_q;
  assign env_level   = env_level_q;
  assign peak_level  = peak_level_q;
  assign clip        = clip_out_q;
  assign level_ready = level_ready_q;

endmodule

// File: tb/tb_audio_level_meter.sv
// Directed bench for audio_level_meter: default instance plus a short-hold instance (HOLD_SAMPLES=8).
// Expected values follow METER_PEAK_DOT_EN where the build option changes them.
module tb_audio_level_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_ready = 1'b0;
  logic [17:0] left_in = '0;
  logic [17:0] right_in = '0;

  logic [7:0]  ld, ld_h;
  logic [17:0] env_level, peak_level, env_h, peak_h;
  logic        clip, clip_h, level_ready, lr_h;

  audio_level_meter u_dut (
    .clockext100MHz (clk),
    .reset          (reset),
    .sample_ready   (sample_ready),
    .left_in        (left_in),
    .right_in       (right_in),
    .ld             (ld),
    .env_level      (env_level),
    .peak_level     (peak_level),
    .clip           (clip),
    .level_ready    (level_ready)
  );

  audio_level_meter #(
    .HOLD_SAMPLES (8)
  ) u_dut_h (
    .clockext100MHz (clk),
    .reset          (reset),
    .sample_ready   (sample_ready),
    .left_in        (left_in),
    .right_in       (right_in),
    .ld             (ld_h),
    .env_level      (env_h),
    .peak_level     (peak_h),
    .clip           (clip_h),
    .level_ready    (lr_h)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int last_lat = 0;
  int pulses;
  int tp_vals[4] = '{600, 1200, 3000, 70000};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One strobe, then wait (bounded) for level_ready; leaves the bench at the ready negedge.
  task automatic send(input int l, input int r);
    int lat;
    @(negedge clk);
    left_in      = 18'(l);
    right_in     = 18'(r);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    lat = 1;
    while (!level_ready && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    last_lat = lat;
    check_eq("level_ready", 32'(level_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state, no strobes
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (level_ready) pulses++;
    end
    check_eq("rst_pulses", 32'(pulses), 32'd0);
    check_eq("rst_ld", 32'(ld), 32'h00);
    check_eq("rst_env", 32'(env_level), 32'd0);
    check_eq("rst_peak", 32'(peak_level), 32'd0);
    check_eq("rst_clip", 32'(clip), 32'd0);

    // Single strobe, latency and bar
    send(4096, -100);
    check_eq("t2_latency", 32'(last_lat), 32'd3);
    check_eq("t2_env", 32'(env_level), 32'd4096);
    check_eq("t2_peak", 32'(peak_level), 32'd4096);
    check_eq("t2_ld", 32'(ld), 32'h0F);
    check_eq("t2_clip", 32'(clip), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("t2_stable_env", 32'(env_level), 32'd4096);
    check_eq("t2_stable_lr", 32'(level_ready), 32'd0);

    // Most negative sample, full scale
    send(0, -131072);
    check_eq("t3_env", 32'(env_level), 32'd131072);
    check_eq("t3_peak", 32'(peak_level), 32'd131072);
    check_eq("t3_ld", 32'(ld), 32'hFF);
    check_eq("t3_clip", 32'(clip), 32'd1);

    // Clip threshold boundary
    do_reset();
    send(130999, 0);
    check_eq("clip_below", 32'(clip), 32'd0);
    check_eq("clip_below_env", 32'(env_level), 32'd130999);
    send(0, -131000);
    check_eq("clip_at", 32'(clip), 32'd1);

    // Attack then decay: one release tick at the 63rd zero sample
    do_reset();
    send(65536, 0);
    for (int i = 1; i <= 64; i++) begin
      send(0, 0);
      if (i == 62) check_eq("t4_env_pre_tick", 32'(env_level), 32'd65536);
    end
    check_eq("t4_env", 32'(env_level), 32'd61440);
`ifdef METER_PEAK_DOT_EN
    check_eq("t4_ld", 32'(ld), 32'hFF);
    check_eq("t4_peak", 32'(peak_level), 32'd65536);
`else
    check_eq("t4_ld", 32'(ld), 32'h7F);
    check_eq("t4_peak", 32'(peak_level), 32'd61440);
`endif

    // Reset while a strobe is in flight
    @(negedge clk);
    left_in      = 18'd1000;
    right_in     = '0;
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    repeat (8) begin
      if (level_ready) pulses++;
      @(negedge clk);
    end
    check_eq("t6_pulses", 32'(pulses), 32'd0);
    check_eq("t6_ld", 32'(ld), 32'h00);
    check_eq("t6_env", 32'(env_level), 32'd0);
    check_eq("t6_peak", 32'(peak_level), 32'd0);
    check_eq("t6_clip", 32'(clip), 32'd0);
    send(4096, 0);
    check_eq("t6_latency", 32'(last_lat), 32'd3);
    check_eq("t6_env_after", 32'(env_level), 32'd4096);
    check_eq("t6_ld_after", 32'(ld), 32'h0F);

    // Back-to-back strobes
    do_reset();
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (level_ready) pulses++;
      if (i < 4) begin
        sample_ready = 1'b1;
        left_in      = 18'(tp_vals[i]);
        right_in     = '0;
      end else begin
        sample_ready = 1'b0;
      end
    end
    check_eq("tp_pulses", 32'(pulses), 32'd4);
    check_eq("tp_env", 32'(env_level), 32'd70000);
    check_eq("tp_peak", 32'(peak_level), 32'd70000);
    check_eq("tp_ld", 32'(ld), 32'hFF);
    check_eq("tp_clip", 32'(clip), 32'd0);

    // Peak hold on the short-hold instance
    do_reset();
    send(8192, 0);
    check_eq("t5_env", 32'(env_h), 32'd8192);
    check_eq("t5_ld", 32'(ld_h), 32'h1F);
    for (int i = 1; i <= 64; i++) begin
      send(0, 0);
      if (i == 8) begin
        check_eq("t5_peak_hold8", 32'(peak_h), 32'd8192);
        check_eq("t5_clip8", 32'(clip_h), 32'd0);
      end
      if (i == 62) check_eq("t5_peak62", 32'(peak_h), 32'd8192);
    end
    check_eq("t5_env_end", 32'(env_h), 32'd7680);
    check_eq("t5_peak_end", 32'(peak_h), 32'd7680);
    check_eq("t5_clip_end", 32'(clip_h), 32'd0);

    // Clip hold: held for 7 further samples, cleared on the 8th
    do_reset();
    send(131071, 0);
    check_eq("ch_clip_set", 32'(clip_h), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      send(0, 0);
      if (i == 7) check_eq("ch_clip7", 32'(clip_h), 32'd1);
      if (i == 8) begin
        check_eq("ch_clip8", 32'(clip_h), 32'd0);
        check_eq("ch_clip8_long", 32'(clip), 32'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
